// File: rtl/sram_port_arbiter_if.sv
// Channel-side and SRAM-side signals of the SRAM port arbiter, bundled as one interface.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM.
interface sram_port_arbiter_if #(
  parameter int NCH = 2,
  parameter int DW  = 32
);
  localparam int BW = DW / 8;

  logic [NCH-1:0]    ch_req;
  logic [NCH*BW-1:0] ch_wen;
  logic [NCH*32-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH*DW-1:0] ch_rdata;
  logic [NCH-1:0]    ch_done;
  logic              sram_en;
  logic [BW-1:0]     sram_wen;
  logic [31:0]       sram_addr;
  logic [DW-1:0]     sram_wdata;
  logic [DW-1:0]     sram_rdata;

  modport slave (
    input  ch_req, ch_wen, ch_addr, ch_wdata, sram_rdata,
    output ch_rdata, ch_done, sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output ch_req, ch_wen, ch_addr, ch_wdata, sram_rdata,
    input  ch_rdata, ch_done, sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NCH channels,
// one transaction in flight, with optional kseg0/kseg1 address folding.
module sram_port_arbiter #(
  parameter int NCH    = 2,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int MAP_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  sram_port_arbiter_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [BW-1:0]     wen_q, wen_d;
  logic [31:0]       addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [NCH*DW-1:0] rdata_q, rdata_d;
  logic [IW-1:0]     pick;
  logic              found;
  int                rr_idx;
  logic              en_o;
  logic [BW-1:0]     wen_o;
  logic [NCH-1:0]    done_o;

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if (MAP_EN != 0 && (a[31:29] == 3'b100 || a[31:29] == 3'b101))
      return {3'b000, a[28:0]};
    return a;
  endfunction

  // Rotating priority: first requester at or after last_grant+1 wins.
  always_comb begin
    pick   = last_q;
    found  = 1'b0;
    rr_idx = 0;
    for (int i = 1; i <= NCH; i++) begin
      rr_idx = int'(last_q) + i;
      if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
      if (!found && bus.ch_req[rr_idx]) begin
        found = 1'b1;
        pick  = IW'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NCH - 1);
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // The operand latch doubles as the sram_addr/sram_wdata holding registers.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          grant_d = pick;
          last_d  = pick;
          wen_d   = bus.ch_wen[int'(pick)*BW +: BW];
          addr_d  = map_addr(bus.ch_addr[int'(pick)*32 +: 32]);
          wdata_d = bus.ch_wdata[int'(pick)*DW +: DW];
        end
      end
      ISSUE: begin
        cnt_d   = 3'(RD_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          if (wen_q == '0) rdata_d[int'(grant_q)*DW +: DW] = bus.sram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    en_o   = 1'b0;
    wen_o  = '0;
    done_o = '0;
    if (state_q == ISSUE) begin
      en_o  = 1'b1;
      wen_o = wen_q;
    end
    if (state_q == WAIT && cnt_q == 3'd1) done_o[grant_q] = 1'b1;
  end

  assign bus.sram_en    = en_o;
  assign bus.sram_wen   = wen_o;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.ch_done    = done_o;
  assign bus.ch_rdata   = rdata_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: instance A with RD_LAT=1, instance B with RD_LAT=3.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;
  int   g;
  logic [31:0] exp_rr [4];

  sram_port_arbiter_if #(.NCH(2), .DW(32)) ifa ();
  sram_port_arbiter_if #(.NCH(2), .DW(32)) ifb ();

  sram_port_arbiter #(.NCH(2), .DW(32), .RD_LAT(1), .MAP_EN(1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa)
  );
  sram_port_arbiter #(.NCH(2), .DW(32), .RD_LAT(3), .MAP_EN(1)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    exp_rr = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0100, 32'h0000_0200};
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.ch_req = '0; ifa.ch_wen = '0; ifa.ch_addr = '0; ifa.ch_wdata = '0; ifa.sram_rdata = '0;
    ifb.ch_req = '0; ifb.ch_wen = '0; ifb.ch_addr = '0; ifb.ch_wdata = '0; ifb.sram_rdata = '0;
    repeat (2) @(negedge clk);
    check_val("rst_en",    64'(ifa.sram_en),    64'd0);
    check_val("rst_wen",   64'(ifa.sram_wen),   64'd0);
    check_val("rst_addr",  64'(ifa.sram_addr),  64'd0);
    check_val("rst_wdata", 64'(ifa.sram_wdata), 64'd0);
    check_val("rst_done",  64'(ifa.ch_done),    64'd0);
    check_val("rst_rdata", ifa.ch_rdata,        64'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Single mapped read on ch0
    ifa.ch_req = 2'b01; ifa.ch_addr[31:0] = 32'h8000_0010; ifa.sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_val("rd_en",    64'(ifa.sram_en),   64'd1);
    check_val("rd_addr",  64'(ifa.sram_addr), 64'h0000_0010);
    check_val("rd_wen",   64'(ifa.sram_wen),  64'd0);
    check_val("rd_done0", 64'(ifa.ch_done),   64'd0);
    @(negedge clk);
    check_val("rd_en_off", 64'(ifa.sram_en),  64'd0);
    check_val("rd_done",   64'(ifa.ch_done),  64'b01);
    ifa.ch_req = 2'b00;
    @(negedge clk);
    check_val("rd_data",  ifa.ch_rdata,       64'h0000_0000_DEAD_BEEF);
    check_val("rd_done1", 64'(ifa.ch_done),   64'd0);

    // Early drop: ch0 releases its request right after the grant
    ifa.ch_req = 2'b01; ifa.ch_addr[31:0] = 32'h0000_0020; ifa.sram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_val("drop_en",   64'(ifa.sram_en),   64'd1);
    check_val("drop_addr", 64'(ifa.sram_addr), 64'h0000_0020);
    ifa.ch_req = 2'b00;
    @(negedge clk);
    check_val("drop_done", 64'(ifa.ch_done),   64'b01);
    @(negedge clk);
    check_val("drop_data", ifa.ch_rdata,       64'h0000_0000_CAFE_F00D);

    // Partial write on ch1 through kseg1
    ifa.ch_req = 2'b10; ifa.ch_wen[7:4] = 4'b0011;
    ifa.ch_addr[63:32] = 32'hBFC0_0004; ifa.ch_wdata[63:32] = 32'h1234_5678;
    @(negedge clk);
    check_val("wr_en",    64'(ifa.sram_en),    64'd1);
    check_val("wr_wen",   64'(ifa.sram_wen),   64'b0011);
    check_val("wr_addr",  64'(ifa.sram_addr),  64'h1FC0_0004);
    check_val("wr_wdata", 64'(ifa.sram_wdata), 64'h1234_5678);
    @(negedge clk);
    check_val("wr_done",      64'(ifa.ch_done),   64'b10);
    check_val("wr_wen_off",   64'(ifa.sram_wen),  64'd0);
    check_val("wr_addr_hold", 64'(ifa.sram_addr), 64'h1FC0_0004);
    ifa.ch_req = 2'b00;
    @(negedge clk);
    check_val("wr_rdata", ifa.ch_rdata, 64'h0000_0000_CAFE_F00D);

    // Contention: both channels request continuously, grants must alternate
    ifa.ch_wen = '0; ifa.ch_addr = {32'h0000_0200, 32'h0000_0100};
    ifa.ch_req = 2'b11;
    g = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val("rr_onehot", 64'($countones(ifa.ch_done) <= 1), 64'd1);
      if (ifa.sram_en && g < 4) begin
        check_val("rr_addr", 64'(ifa.sram_addr), 64'(exp_rr[g]));
        g++;
      end
    end
    check_val("rr_grants", 64'(g), 64'd4);
    ifa.ch_req = 2'b00;
    repeat (3) @(negedge clk);

    // Instance B: unmapped read, RD_LAT=3
    ifb.ch_req = 2'b01; ifb.ch_addr[31:0] = 32'h0040_0000; ifb.sram_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    check_val("lat_en",   64'(ifb.sram_en),   64'd1);
    check_val("lat_addr", 64'(ifb.sram_addr), 64'h0040_0000);
    @(negedge clk);
    check_val("lat_d2", 64'(ifb.ch_done), 64'd0);
    @(negedge clk);
    check_val("lat_d3", 64'(ifb.ch_done), 64'd0);
    @(negedge clk);
    check_val("lat_d4", 64'(ifb.ch_done), 64'b01);
    ifb.ch_req = 2'b00;
    @(negedge clk);
    check_val("lat_data", ifb.ch_rdata, 64'h0000_0000_0BAD_CAFE);

    // Instance B: reset in the middle of WAIT abandons the transaction
    ifb.ch_req = 2'b01; ifb.ch_addr[31:0] = 32'hA000_0040;
    ifb.ch_wen[3:0] = 4'hF; ifb.ch_wdata[31:0] = 32'h55AA_55AA;
    @(negedge clk);
    check_val("mr_en",   64'(ifb.sram_en),   64'd1);
    check_val("mr_addr", 64'(ifb.sram_addr), 64'h0000_0040);
    check_val("mr_wen",  64'(ifb.sram_wen),  64'hF);
    ifb.ch_req = 2'b00;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check_val("mr_done",  64'(ifb.ch_done),    64'd0);
    check_val("mr_en0",   64'(ifb.sram_en),    64'd0);
    check_val("mr_addr0", 64'(ifb.sram_addr),  64'd0);
    check_val("mr_wd0",   64'(ifb.sram_wdata), 64'd0);
    check_val("mr_rd0",   ifb.ch_rdata,        64'd0);
    @(negedge clk);
    check_val("mr_done2", 64'(ifb.ch_done), 64'd0);
    rst_b = 1'b0;
    ifb.ch_wen = '0; ifb.ch_addr = {32'h0000_0200, 32'h0000_0100};
    ifb.ch_req = 2'b11;
    @(negedge clk);
    check_val("mr_first_en",   64'(ifb.sram_en),   64'd1);
    check_val("mr_first_addr", 64'(ifb.sram_addr), 64'h0000_0100);
    check_val("mr_first_wen",  64'(ifb.sram_wen),  64'd0);
    ifb.ch_req = 2'b00;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
